draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Shares the single VGA adapter pixel-write port among the player and up to N_REQ-1 enemies.
- Each requester issues a one-cycle move pulse with its current top-left coordinate, square width and colour.
- The scheduler arbitrates round-robin. For the granted requester it erases the square at the previously drawn position, then draws the square at the new position, one pixel per clock.
- Sits between player_control/enemy_control instances and the VGA adapter.

Parameters:
N_REQ, 4, number of requesters; index 0 is the player, 1..N_REQ-1 are enemies
SCREEN_W, 160, screen width in pixels; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, screen height in pixels; pixels with y >= SCREEN_H are clipped

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_move  input  N_REQ  per-requester move pulse, sampled each clk
req_x  input  8*N_REQ  top-left x of requester i at bits [8i+7:8i]
req_y  input  7*N_REQ  top-left y of requester i at bits [7i+6:7i]
req_width  input  3*N_REQ  square width of requester i, 0..7
req_colour  input  3*N_REQ  RGB draw colour of requester i
vga_x  output  8  pixel x to VGA adapter
vga_y  output  7  pixel y to VGA adapter
vga_colour  output  3  pixel colour
vga_plot  output  1  write enable for the current pixel
busy  output  1  high whenever state != IDLE
grant_idx  output  $clog2(N_REQ)  index of the requester being serviced
done  output  1  one-cycle pulse when a requester's service completes

Behaviour:
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, grant_idx=0, done=0, pending=0, drawn=0, rr_ptr=0, state=IDLE.
- Reset mid-operation abandons the service immediately with no further plots. Screen contents are not cleaned up unless the optional feature is enabled.
- Pending: req_move[i]=1 at an edge sets pending[i]. Repeated pulses while pending coalesce into one service.
- Clearing pending: pending[i] clears on the edge that grants i. A pulse from i on that same edge keeps it set, so i is serviced again later.
- Arbitration (IDLE only): search pending starting at rr_ptr, wrapping modulo N_REQ. The first set bit wins.
- On grant:
  - grant_idx <= i; rr_ptr <= i+1 mod N_REQ.
  - Capture new_x, new_y, width and colour from the inputs at that edge. Later input changes are ignored.
  - If drawn[i]=1, go to ERASE; otherwise go to DRAW.
  - width=0: go straight to DONE with no plots; per-requester state is not updated.
- Per-requester registers: old_x[i], old_y[i], old_w[i] and drawn[i]. They are updated only on DRAW completion.
- ERASE: scans old_w x old_w pixels from (old_x, old_y) at colour 0. Then go to DRAW.
- DRAW: scans width x width pixels from (new_x, new_y) at the captured colour. Then go to DONE.
- Scan order is row-major, x inner: (x0,y0), (x0+1,y0) ... (x0+w-1,y0), (x0,y0+1) ... One pixel per clock.
- Clipping:
  - Pixel coordinates are computed 9 bits wide.
  - If x >= SCREEN_W or y >= SCREEN_H, vga_plot=0 for that cycle; the cycle is still consumed.
  - vga_x/vga_y carry the low bits of the computed coordinate.
- Outputs are registered. A pixel scanned in cycle k appears on vga_* in cycle k+1.
- Timing for a requester pulsed at edge E0 with state IDLE and no competitors:
  - grant at E1;
  - first vga_plot high after E2;
  - w*w pixels for DRAW only, 2*w*w when ERASE is needed;
  - DONE state one cycle; done pulses for one cycle; return to IDLE.
- Back-to-back grants: IDLE is re-entered for at least one cycle between services, so grant-to-grant spacing is at least total pixels + 2.
- drawn[i] is never cleared except by reset.

Optional Feature:
- Macro: CLEAR_ON_RESET_EN.
- Defined:
  - Reset enters state CLEAR instead of IDLE.
  - CLEAR scans all SCREEN_W*SCREEN_H pixels row-major at colour 0, vga_plot=1, busy=1: 19200 cycles at defaults.
  - req_move pulses during CLEAR still set pending.
  - On completion, go to IDLE without pulsing done.
- Undefined: reset enters IDLE directly and the CLEAR state does not exist.

Test Plan:
- Player first draw: req_move[0] pulse, x=80, y=115, w=3, colour=3'b111.
  - Expect 9 plots of colour 111 in order (80,115), (81,115), (82,115), (80,116) ... (82,117), with no erase.
  - Expect done one cycle after the last plot; busy high throughout.
- Player move: after the first draw, pulse again with x=79.
  - Expect 9 plots of colour 0 at (80..82, 115..117), then 9 plots of colour 111 at (79..81, 115..117).
- Round-robin: requesters 1, 2 and 3 pulse on the same edge with rr_ptr=2.
  - Expect service order 2, 3, 1 on grant_idx, with three done pulses.
- Coalesce/re-arm: requester 1 pulses twice before grant, then again on its grant edge.
  - Expect exactly two services of requester 1.
- Clipping: w=5 at x=158, y=118.
  - Expect 25 scan cycles; vga_plot high only for (158..159, 118..119), i.e. 4 pixels.
- Reset mid-ERASE: assert reset during the 3rd erase pixel.
  - Expect vga_plot=0, busy=0 and pending=0 the next cycle.
  - A fresh pulse then draws without erase, since drawn was cleared.
  - With CLEAR_ON_RESET_EN, expect instead 19200 clear plots first, with busy high throughout.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// Request bus from the player/enemy controllers and the pixel-write bus toward the VGA adapter.
interface draw_scheduler_if #(
  parameter int N_REQ = 4
) ();
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_move;
  logic [8*N_REQ-1:0] req_x;
  logic [7*N_REQ-1:0] req_y;
  logic [3*N_REQ-1:0] req_width;
  logic [3*N_REQ-1:0] req_colour;

  logic [7:0]         vga_x;
  logic [6:0]         vga_y;
  logic [2:0]         vga_colour;
  logic               vga_plot;
  logic               busy;
  logic [IW-1:0]      grant_idx;
  logic               done;

  modport master (
    output req_move, req_x, req_y, req_width, req_colour,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, grant_idx, done
  );

  modport slave (
    input  req_move, req_x, req_y, req_width, req_colour,
    output vga_x, vga_y, vga_colour, vga_plot, busy, grant_idx, done
  );
endinterface

// File: rtl/draw_scheduler.sv
// Round-robin owner of the VGA pixel port: erases a requester's old square, then draws the new one.
// Build option CLEAR_ON_RESET_EN: blank the whole screen after reset before serving any request.
module draw_scheduler #(
  parameter int N_REQ    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic            clk,
  input  logic            reset,
  draw_scheduler_if.slave bus
);
  localparam int         IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);

`ifdef CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE, S_CLEAR} state_t;
  localparam state_t     S_RESET    = S_CLEAR;
  localparam logic [7:0] CLR_X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] CLR_Y_LAST = 7'(SCREEN_H - 1);
`else
  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;
  localparam state_t     S_RESET    = S_IDLE;
`endif

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] drawn_q, drawn_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [7:0]       new_x_q, new_x_d;
  logic [6:0]       new_y_q, new_y_d;
  logic [2:0]       new_w_q, new_w_d;
  logic [2:0]       colour_q, colour_d;
  logic [2:0]       col_q, col_d;
  logic [2:0]       row_q, row_d;
  logic [7:0]       old_x_q [N_REQ];
  logic [7:0]       old_x_d [N_REQ];
  logic [6:0]       old_y_q [N_REQ];
  logic [6:0]       old_y_d [N_REQ];
  logic [2:0]       old_w_q [N_REQ];
  logic [2:0]       old_w_d [N_REQ];
  logic [7:0]       vga_x_q, vga_x_d;
  logic [6:0]       vga_y_q, vga_y_d;
  logic [2:0]       vga_colour_q, vga_colour_d;
  logic             vga_plot_q, vga_plot_d;
  logic             done_q, done_d;
`ifdef CLEAR_ON_RESET_EN
  logic [7:0]       clr_x_q, clr_x_d;
  logic [6:0]       clr_y_q, clr_y_d;
`endif

  logic [7:0] req_x_a [N_REQ];
  logic [6:0] req_y_a [N_REQ];
  logic [2:0] req_w_a [N_REQ];
  logic [2:0] req_c_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_x_a[g] = bus.req_x[8*g +: 8];
    assign req_y_a[g] = bus.req_y[7*g +: 7];
    assign req_w_a[g] = bus.req_width[3*g +: 3];
    assign req_c_a[g] = bus.req_colour[3*g +: 3];
  end

  // Round-robin search: first pending bit at or after rr_ptr, wrapping.
  logic          arb_found;
  logic [IW-1:0] arb_win;
  logic [IW-1:0] arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!arb_found && pending_q[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx;
      end
    end
  end

  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_w;
  logic [2:0] scan_c;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic       last_col;
  logic       last_pix;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | bus.req_move;
    drawn_d      = drawn_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_w_d      = new_w_q;
    colour_d     = colour_q;
    col_d        = col_q;
    row_d        = row_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    old_w_d      = old_w_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    done_d       = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    clr_x_d      = clr_x_q;
    clr_y_d      = clr_y_q;
`endif

    if (state_q == S_ERASE) begin
      scan_x = old_x_q[grant_q];
      scan_y = old_y_q[grant_q];
      scan_w = old_w_q[grant_q];
      scan_c = 3'd0;
    end else begin
      scan_x = new_x_q;
      scan_y = new_y_q;
      scan_w = new_w_q;
      scan_c = colour_q;
    end

    // Nine bits so squares hanging off the right/bottom edge clip instead of wrapping.
    pix_x    = {1'b0, scan_x} + {6'b0, col_q};
    pix_y    = {2'b0, scan_y} + {6'b0, row_q};
    last_col = (col_q == scan_w - 3'd1);
    last_pix = last_col && (row_q == scan_w - 3'd1);

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          pending_d[arb_win] = bus.req_move[arb_win];
          grant_d            = arb_win;
          rr_ptr_d           = (arb_win == IW'(N_REQ - 1)) ? '0 : arb_win + IW'(1);
          new_x_d            = req_x_a[arb_win];
          new_y_d            = req_y_a[arb_win];
          new_w_d            = req_w_a[arb_win];
          colour_d           = req_c_a[arb_win];
          col_d              = '0;
          row_d              = '0;
          if (req_w_a[arb_win] == 3'd0) begin
            state_d = S_DONE;
          end else if (drawn_q[arb_win]) begin
            state_d = S_ERASE;
          end else begin
            state_d = S_DRAW;
          end
        end
      end

      S_ERASE, S_DRAW: begin
        vga_x_d      = pix_x[7:0];
        vga_y_d      = pix_y[6:0];
        vga_colour_d = scan_c;
        vga_plot_d   = (pix_x < SW9) && (pix_y < SH9);
        if (last_col) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
        if (last_pix) begin
          row_d = '0;
          if (state_q == S_ERASE) begin
            state_d = S_DRAW;
          end else begin
            state_d          = S_DONE;
            drawn_d[grant_q] = 1'b1;
            old_x_d[grant_q] = new_x_q;
            old_y_d[grant_q] = new_y_q;
            old_w_d[grant_q] = new_w_q;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

`ifdef CLEAR_ON_RESET_EN
      S_CLEAR: begin
        vga_x_d      = clr_x_q;
        vga_y_d      = clr_y_q;
        vga_colour_d = 3'd0;
        vga_plot_d   = 1'b1;
        if (clr_x_q == CLR_X_LAST) begin
          clr_x_d = '0;
          if (clr_y_q == CLR_Y_LAST) begin
            clr_y_d = '0;
            state_d = S_IDLE;
          end else begin
            clr_y_d = clr_y_q + 7'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 8'd1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RESET;
      pending_q    <= '0;
      drawn_q      <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_w_q      <= '0;
      colour_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        old_x_q[i] <= '0;
        old_y_q[i] <= '0;
        old_w_q[i] <= '0;
      end
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef CLEAR_ON_RESET_EN
      clr_x_q      <= '0;
      clr_y_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      drawn_q      <= drawn_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_w_q      <= new_w_d;
      colour_q     <= colour_d;
      col_q        <= col_d;
      row_q        <= row_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      old_w_q      <= old_w_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
`ifdef CLEAR_ON_RESET_EN
      clr_x_q      <= clr_x_d;
      clr_y_q      <= clr_y_d;
`endif
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.grant_idx  = grant_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed scenarios and random move pulses against a per-service pixel-list model.
`timescale 1ns/1ps
module tb_draw_scheduler;
  localparam int N  = 4;
  localparam int SW = 160;
  localparam int SH = 120;
`ifdef CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  draw_scheduler_if #(.N_REQ(N)) bus ();

  draw_scheduler #(.N_REQ(N), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit scan;
    bit plot;
    int x;
    int y;
    int c;
    bit busy;
    bit done;
  } exp_t;

  int   r_x [N];
  int   r_y [N];
  int   r_w [N];
  int   r_c [N];
  bit   mv  [N];

  exp_t exp_q[$];
  bit   m_pend  [N];
  bit   m_drawn [N];
  int   m_ox [N];
  int   m_oy [N];
  int   m_ow [N];
  int   m_rr;
  int   m_grant;
  bit   m_rst;

  int n_vec = 0;
  int n_err = 0;
  int plot_cnt;
  int done_cnt;
  int done_order[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_x[8*i +: 8]      = 8'(r_x[i]);
      bus.req_y[7*i +: 7]      = 7'(r_y[i]);
      bus.req_width[3*i +: 3]  = 3'(r_w[i]);
      bus.req_colour[3*i +: 3] = 3'(r_c[i]);
      bus.req_move[i]          = mv[i];
    end
  endtask

  function automatic void push_square(int bx, int by, int w, int c);
    exp_t e;
    for (int r = 0; r < w; r++) begin
      for (int k = 0; k < w; k++) begin
        e.scan = 1'b1;
        e.plot = ((bx + k) < SW) && ((by + r) < SH);
        e.x    = (bx + k) % 256;
        e.y    = (by + r) % 128;
        e.c    = c;
        e.busy = 1'b1;
        e.done = 1'b0;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic bit model_busy();
    bit any;
    any = (exp_q.size() != 0);
    for (int i = 0; i < N; i++) any |= m_pend[i];
    return any;
  endfunction

  // One service = one idle-looking cycle, its pixel cycles, then a done cycle with busy already low.
  function automatic void model_edge();
    int   win;
    exp_t e;
    m_rst = reset;
    if (reset) begin
      m_rr = 0;
      m_grant = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        m_pend[i]  = 1'b0;
        m_drawn[i] = 1'b0;
      end
      if (CLR) begin
        e = '{scan: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0, busy: 1'b1, done: 1'b0};
        exp_q.push_back(e);
        for (int y = 0; y < SH; y++) begin
          for (int x = 0; x < SW; x++) begin
            e = '{scan: 1'b1, plot: 1'b1, x: x, y: y, c: 0,
                  busy: !((x == SW - 1) && (y == SH - 1)), done: 1'b0};
            exp_q.push_back(e);
          end
        end
      end
      return;
    end
    win = -1;
    if (exp_q.size() == 0) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && m_pend[(m_rr + k) % N]) win = (m_rr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) m_pend[i] |= mv[i];
    if (win >= 0) begin
      m_pend[win] = mv[win];
      m_grant     = win;
      m_rr        = (win + 1) % N;
      e = '{scan: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0, busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
      if (r_w[win] > 0) begin
        if (m_drawn[win]) push_square(m_ox[win], m_oy[win], m_ow[win], 0);
        push_square(r_x[win], r_y[win], r_w[win], r_c[win]);
        m_drawn[win] = 1'b1;
        m_ox[win]    = r_x[win];
        m_oy[win]    = r_y[win];
        m_ow[win]    = r_w[win];
      end
      e = '{scan: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0, busy: 1'b0, done: 1'b1};
      exp_q.push_back(e);
    end
  endfunction

  task automatic sample_check();
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{scan: 1'b0, plot: 1'b0, x: 0, y: 0, c: 0, busy: 1'b0, done: 1'b0};
    chk("vga_plot",  32'(bus.vga_plot),  32'(e.plot));
    chk("busy",      32'(bus.busy),      32'(e.busy));
    chk("done",      32'(bus.done),      32'(e.done));
    chk("grant_idx", 32'(bus.grant_idx), 32'(m_grant));
    if (e.scan) begin
      chk("vga_x", 32'(bus.vga_x), 32'(e.x));
      chk("vga_y", 32'(bus.vga_y), 32'(e.y));
    end
    if (e.plot) chk("vga_colour", 32'(bus.vga_colour), 32'(e.c));
    if (m_rst) begin
      chk("rst_vga_x",      32'(bus.vga_x),      32'(0));
      chk("rst_vga_y",      32'(bus.vga_y),      32'(0));
      chk("rst_vga_colour", 32'(bus.vga_colour), 32'(0));
    end
    if (bus.vga_plot === 1'b1) plot_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_order.push_back(int'(bus.grant_idx));
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    sample_check();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
  endtask

  task automatic pulse(input int i, input int x, input int y, input int w, input int c);
    r_x[i] = x;
    r_y[i] = y;
    r_w[i] = w;
    r_c[i] = c;
    mv[i]  = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (model_busy() && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'(1));
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt1;
    for (int i = 0; i < N; i++) begin
      r_x[i] = 20 * i;
      r_y[i] = 10;
      r_w[i] = 2;
      r_c[i] = i + 1;
      mv[i]  = 1'b0;
    end
    plot_cnt = 0;
    done_cnt = 0;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    wait_idle(30000);

    // Player first draw: no erase.
    plot_cnt = 0; done_cnt = 0;
    pulse(0, 80, 115, 3, 7);
    wait_idle(200);
    chk("t1_plots", 32'(plot_cnt), 32'(9));
    chk("t1_done",  32'(done_cnt), 32'(1));

    // Player move: erase 9 then draw 9.
    plot_cnt = 0;
    pulse(0, 79, 115, 3, 7);
    wait_idle(200);
    chk("t2_plots", 32'(plot_cnt), 32'(18));

    // Clipped square in the bottom-right corner.
    plot_cnt = 0;
    pulse(3, 158, 118, 5, 5);
    wait_idle(200);
    chk("t3_plots", 32'(plot_cnt), 32'(4));

    // Serve requester 1 so rr_ptr sits at 2, then three-way contention.
    pulse(1, 10, 10, 2, 2);
    wait_idle(200);
    done_order.delete();
    r_x[1] = 30; r_y[1] = 30; r_w[1] = 2; r_c[1] = 1; mv[1] = 1'b1;
    r_x[2] = 60; r_y[2] = 20; r_w[2] = 3; r_c[2] = 4; mv[2] = 1'b1;
    r_x[3] = 100; r_y[3] = 50; r_w[3] = 1; r_c[3] = 6; mv[3] = 1'b1;
    tick();
    wait_idle(500);
    chk("t4_ndone", 32'(done_order.size()), 32'(3));
    if (done_order.size() == 3) begin
      chk("t4_first",  32'(done_order[0]), 32'(2));
      chk("t4_second", 32'(done_order[1]), 32'(3));
      chk("t4_third",  32'(done_order[2]), 32'(1));
    end

    // Coalesce two pulses, then re-arm on the grant edge.
    done_order.delete();
    pulse(0, 40, 40, 4, 6);
    pulse(1, 31, 30, 2, 3);
    tick();
    pulse(1, 32, 30, 2, 3);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_done_seen", 32'(n < 200), 32'(1));
    mv[1] = 1'b1;
    tick();
    wait_idle(500);
    cnt1 = 0;
    foreach (done_order[k]) if (done_order[k] == 1) cnt1++;
    chk("t5_services", 32'(cnt1), 32'(2));

    // Reset while the third erase pixel is being scanned.
    pulse(0, 50, 50, 3, 1);
    tick();
    mv[2] = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_plot", 32'(bus.vga_plot), 32'(0));
    chk("t6_busy", 32'(bus.busy), 32'(CLR));
    wait_idle(30000);
    repeat (10) tick();
    plot_cnt = 0;
    pulse(0, 50, 50, 3, 1);
    wait_idle(200);
    chk("t6_fresh_plots", 32'(plot_cnt), 32'(9));

    // Random pulses with inputs changing every cycle.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r_x[i] = $urandom_range(0, 255);
          r_y[i] = $urandom_range(0, 127);
          r_w[i] = $urandom_range(0, 7);
          r_c[i] = $urandom_range(0, 7);
        end
        mv[i] = ($urandom_range(0, 24) == 0);
      end
      tick();
    end
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
